pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Next-generation fetch PC generator for the 5-stage core. It replaces the fixed two-source branch
//  handling with N prioritised redirect sources. It holds a redirect that arrives while fetch is
//  stalled, and adds a direct-mapped BTB with 2-bit counters for next-PC prediction. It feeds the
//  IF stage and takes redirects from ID/EX/MEM and BTB training from EX.
// PARAMETERS
//  ADDR_W      32     PC / target width
//  RESET_VEC   32'h0  pc_o value in and immediately after reset
//  INST_BYTES  4      sequential increment; power of 2; OFF_W = log2(INST_BYTES)
//  NUM_RDR     2      redirect sources; index NUM_RDR-1 = latest pipe stage = highest priority
//  BTB_DEPTH   16     BTB entries; power of 2, >=2; IDX_W = log2(BTB_DEPTH)
//  EPOCH_W     3      width of redirect epoch counter
// PORTS
//  clk              in   1               clock, all state on posedge
//  rst              in   1               asynchronous, active-high reset
//  stall_i          in   1               1 = fetch stalled, pc_o must hold
//  rdr_valid_i      in   NUM_RDR         per-source redirect request
//  rdr_target_i     in   NUM_RDR*ADDR_W  per-source target; source k at [k*ADDR_W +: ADDR_W]
//  btb_upd_valid_i  in   1               resolved control-flow instruction from EX
//  btb_upd_pc_i     in   ADDR_W          its PC
//  btb_upd_target_i in   ADDR_W          its resolved target
//  btb_upd_taken_i  in   1               its resolved direction
//  pc_o             out  ADDR_W          current fetch PC
//  pc_valid_o       out  1               pc_o is a real fetch address
//  pred_taken_o     out  1               BTB predicts pc_o taken (combinational on pc_o)
//  pred_target_o    out  ADDR_W          predicted target (valid when pred_taken_o)
//  epoch_o          out  EPOCH_W         increments once per cycle containing any redirect
// BEHAVIOUR
//  Reset (async): pc_o=RESET_VEC, pc_valid_o=0, epoch_o=0, pending cleared, all BTB valid bits=0.
//   Counters/tags/targets are not reset.
//  pc_valid_o goes to 1 on the first posedge after rst deasserts and stays 1 until the next reset.
//  Winner: highest-index asserted rdr_valid_i bit. Its target has low OFF_W bits forced to 0.
//  Next-PC, stall_i=0, priority order:
//   (1) winner target; (2) pending target; (3) pred_target_o if pred_taken_o; (4) pc_o+INST_BYTES.
//   pc_o+INST_BYTES wraps modulo 2^ADDR_W.
//   Latency: a redirect in cycle t appears on pc_o after posedge t.
//  stall_i=1: pc_o holds. A winner in the same cycle is written to the pending register;
//   a later stalled-cycle winner overwrites pending (newest wins).
//  Pending is cleared on the first unstalled edge, whether it is consumed or superseded by a fresh winner.
//  epoch_o += 1 (wraps) on every edge where |rdr_valid_i, whether stalled or not.
//  BTB entry: {valid, tag[ADDR_W-IDX_W-OFF_W], target[ADDR_W], ctr[2]}.
//   Index = pc[OFF_W +: IDX_W]; tag = upper bits.
//  Lookup on pc_o: pred_taken_o = valid & tag_hit & ctr[1]; pred_target_o = entry target.
//  Update on btb_upd_valid_i:
//   hit   -> ctr saturating +1 if taken, -1 if not taken; target overwritten when taken.
//   miss & taken     -> allocate: valid=1, tag, target, ctr=2'b10.
//   miss & not taken -> no change.
//  Update and lookup in the same cycle, same index: lookup sees old contents; the write takes
//   effect after the edge.
//  No BTB update is performed while rst is asserted.
// STRUCTURE
//  Shared defines/package: ADDR_W, EPOCH_W, INST_BYTES, RESET_VEC, 2-bit counter encodings
//   (SNT=00, WNT=01, WT=10, ST=11), BTB entry field layout.
//  One sub-module: pc_btb_dm (direct-mapped BTB: lookup port + update port, parameters
//   BTB_DEPTH/ADDR_W/OFF_W). Redirect arbitration, pending register and epoch counter stay in pc_gen.
// TESTING
//  T1 reset: hold rst, release, run 3 unstalled cycles, no redirects
//   -> pc_o 0,0(pc_valid_o=0),4,8,C; epoch_o=0.
//  T2 priority: NUM_RDR=2; rdr_valid_i=2'b11, targets {0x200, 0x100}, unstalled
//   -> next pc_o=0x200; epoch_o+1. Then 0x202 from src0 -> pc_o=0x200 (aligned).
//  T3 stall capture: stall_i=1 for 4 cycles; src0 redirect 0x40 in cycle 1, src1 0x80 in cycle 3
//   -> pc_o held; after release pc_o=0x80, then 0x84; epoch_o +2.
//  T4 BTB train: update pc=0x10, target 0x300, taken, twice; then run from 0x0
//   -> at pc_o=0x10 pred_taken_o=1, next pc_o=0x300. Two not-taken updates -> prediction drops to 0.
//  T5 redirect beats prediction: pc_o=0x10 with BTB hit taken, same cycle src0 redirect 0x500
//   -> pc_o=0x500.
//  T6 async reset mid-stall with pending 0x80: rst pulse between edges
//   -> pc_o=RESET_VEC immediately; pending lost; BTB predicts nothing.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants, 2-bit counter encodings and BTB entry layout for the fetch PC generator.
package pc_gen_pkg;

    localparam int          DEF_ADDR_W     = 32;
    localparam int          DEF_EPOCH_W    = 3;
    localparam int          DEF_INST_BYTES = 4;
    localparam int          DEF_NUM_RDR    = 2;
    localparam int          DEF_BTB_DEPTH  = 16;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h0;

    // Branch direction counter; bit 1 set means "predict taken".
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // BTB entry layout, MSB first: {valid, tag, target, ctr}.
    // With the default geometry the tag is ADDR_W - log2(DEPTH) - log2(INST_BYTES) bits.
    localparam int DEF_OFF_W   = $clog2(DEF_INST_BYTES);
    localparam int DEF_IDX_W   = $clog2(DEF_BTB_DEPTH);
    localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;
    localparam int DEF_ENTRY_W = 1 + DEF_TAG_W + DEF_ADDR_W + 2;

    // Saturating counter step towards the resolved direction.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        if (taken) begin
            if (c != CTR_ST) n = ctr_e'(c + 2'd1);
        end else begin
            if (c != CTR_SNT) n = ctr_e'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/pc_btb_dm.sv
// Direct-mapped branch target buffer: one combinational lookup port, one update port.
// Lookup always sees the contents from before the current edge's update.
module pc_btb_dm
    import pc_gen_pkg::*;
#(
    parameter int BTB_DEPTH = DEF_BTB_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int OFF_W     = DEF_OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lkp_pc_i,
    output logic              lkp_taken_o,
    output logic [ADDR_W-1:0] lkp_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_taken_i
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    logic              valid_q  [BTB_DEPTH];
    logic              valid_d  [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_q    [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_d    [BTB_DEPTH];
    logic [ADDR_W-1:0] target_q [BTB_DEPTH];
    logic [ADDR_W-1:0] target_d [BTB_DEPTH];
    ctr_e              ctr_q    [BTB_DEPTH];
    ctr_e              ctr_d    [BTB_DEPTH];

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    // Instruction-offset bits never take part in indexing or tagging.
    logic unused_low_bits;
    assign unused_low_bits = ^{lkp_pc_i[OFF_W-1:0], upd_pc_i[OFF_W-1:0]};

    assign lkp_idx = lkp_pc_i[OFF_W +: IDX_W];
    assign lkp_tag = lkp_pc_i[ADDR_W-1 -: TAG_W];
    assign upd_idx = upd_pc_i[OFF_W +: IDX_W];
    assign upd_tag = upd_pc_i[ADDR_W-1 -: TAG_W];

    // Lookup: predict taken only on a valid tag hit whose counter leans taken.
    always_comb begin
        lkp_taken_o  = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag) && ctr_q[lkp_idx][1];
        lkp_target_o = target_q[lkp_idx];
    end

    // Update: train the counter on a hit, allocate on a taken miss, ignore a not-taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_valid_i) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken_i);
                if (upd_taken_i) target_d[upd_idx] = upd_target_i;
            end else if (upd_taken_i) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target_i;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    // Valid bits are the only reset state; holding them at 0 during reset also makes
    // any payload written meanwhile unreachable, since a later allocation rewrites it all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) valid_q[i] <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Entry payload (tag, target, counter) is plain storage without reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirects, stall-held pending redirect, epoch counter
// and BTB-based next-PC prediction.
// rdr_valid_i and btb_upd_valid_i are single-cycle valid-only strobes with no ready:
// the generator accepts every asserted request on the edge that ends the cycle.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC  = DEF_RESET_VEC,
    parameter int                INST_BYTES = DEF_INST_BYTES,
    parameter int                NUM_RDR    = DEF_NUM_RDR,
    parameter int                BTB_DEPTH  = DEF_BTB_DEPTH,
    parameter int                EPOCH_W    = DEF_EPOCH_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic [NUM_RDR-1:0]        rdr_valid_i,
    input  logic [NUM_RDR*ADDR_W-1:0] rdr_target_i,
    input  logic                      btb_upd_valid_i,
    input  logic [ADDR_W-1:0]         btb_upd_pc_i,
    input  logic [ADDR_W-1:0]         btb_upd_target_i,
    input  logic                      btb_upd_taken_i,
    output logic [ADDR_W-1:0]         pc_o,
    output logic                      pc_valid_o,
    output logic                      pred_taken_o,
    output logic [ADDR_W-1:0]         pred_target_o,
    output logic [EPOCH_W-1:0]        epoch_o
);

    localparam int                OFF_W      = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d;

    logic               rdr_any;
    logic [ADDR_W-1:0]  win_tgt;

    pc_btb_dm #(
        .BTB_DEPTH (BTB_DEPTH),
        .ADDR_W    (ADDR_W),
        .OFF_W     (OFF_W)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc_i     (pc_q),
        .lkp_taken_o  (pred_taken_o),
        .lkp_target_o (pred_target_o),
        .upd_valid_i  (btb_upd_valid_i),
        .upd_pc_i     (btb_upd_pc_i),
        .upd_target_i (btb_upd_target_i),
        .upd_taken_i  (btb_upd_taken_i)
    );

    // Winner is the highest-index requester (latest pipe stage); target is instruction-aligned.
    always_comb begin
        rdr_any = |rdr_valid_i;
        win_tgt = '0;
        for (int k = 0; k < NUM_RDR; k++) begin
            if (rdr_valid_i[k]) win_tgt = rdr_target_i[k*ADDR_W +: ADDR_W] & ALIGN_MASK;
        end
    end

    // Next PC, pending capture while stalled, and epoch bump on any redirect.
    always_comb begin
        pc_d         = pc_q;
        pc_valid_d   = 1'b1;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        epoch_d      = epoch_q + EPOCH_W'(rdr_any);
        if (stall_i) begin
            if (rdr_any) begin
                pend_valid_d = 1'b1;
                pend_tgt_d   = win_tgt;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (rdr_any)           pc_d = win_tgt;
            else if (pend_valid_q) pc_d = pend_tgt_q;
            else if (pred_taken_o) pc_d = pred_target_o;
            else                   pc_d = pc_q + ADDR_W'(INST_BYTES);
        end
    end

    // Architectural PC state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            pc_valid_q   <= 1'b0;
            epoch_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            epoch_q      <= epoch_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign epoch_o    = epoch_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level reference model of the fetch PC and the BTB.
module tb_pc_gen;

    localparam int AW    = 32;
    localparam int NR    = 2;
    localparam int EW    = 3;
    localparam int IB    = 4;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic             stall;
    logic [NR-1:0]    rdr_valid;
    logic [NR*AW-1:0] rdr_target;
    logic             upd_valid;
    logic [AW-1:0]    upd_pc;
    logic [AW-1:0]    upd_target;
    logic             upd_taken;
    logic [AW-1:0]    pc_o;
    logic             pc_valid_o;
    logic             pred_taken_o;
    logic [AW-1:0]    pred_target_o;
    logic [EW-1:0]    epoch_o;

    pc_gen #(
        .ADDR_W     (AW),
        .RESET_VEC  (32'h0),
        .INST_BYTES (IB),
        .NUM_RDR    (NR),
        .BTB_DEPTH  (DEPTH),
        .EPOCH_W    (EW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .rdr_valid_i      (rdr_valid),
        .rdr_target_i     (rdr_target),
        .btb_upd_valid_i  (upd_valid),
        .btb_upd_pc_i     (upd_pc),
        .btb_upd_target_i (upd_target),
        .btb_upd_taken_i  (upd_taken),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .epoch_o          (epoch_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [AW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned tag;
        logic [AW-1:0] target;
        int ctr;
    } ent_t;

    logic [AW-1:0] m_pc;
    bit            m_valid;
    int            m_epoch;
    bit            m_pend;
    logic [AW-1:0] m_pend_t;
    ent_t          m_btb[int];

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_epoch = 0;
        m_pend  = 1'b0;
        m_btb.delete();
    endtask

    function automatic void model_lookup(input logic [AW-1:0] pc, output bit taken, output logic [AW-1:0] tgt);
        int idx;
        int unsigned tag;
        idx   = int'((pc / IB) % DEPTH);
        tag   = pc / (IB * DEPTH);
        taken = 1'b0;
        tgt   = '0;
        if (m_btb.exists(idx) && m_btb[idx].tag == tag) begin
            tgt   = m_btb[idx].target;
            taken = (m_btb[idx].ctr >= 2);
        end
    endfunction

    task automatic model_step();
        bit            any;
        logic [AW-1:0] win;
        logic [AW-1:0] raw;
        bit            pt;
        logic [AW-1:0] ptg;
        int            idx;
        int unsigned   tag;
        any = 1'b0;
        win = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (rdr_valid[k]) begin
                raw = rdr_target[k*AW +: AW];
                win = raw - (raw % IB);
                any = 1'b1;
                break;
            end
        end
        model_lookup(m_pc, pt, ptg);
        if (stall) begin
            if (any) begin
                m_pend   = 1'b1;
                m_pend_t = win;
            end
        end else begin
            if (any)         m_pc = win;
            else if (m_pend) m_pc = m_pend_t;
            else if (pt)     m_pc = ptg;
            else             m_pc = m_pc + IB;
            m_pend = 1'b0;
        end
        m_valid = 1'b1;
        if (any) m_epoch = (m_epoch + 1) % (1 << EW);
        if (upd_valid) begin
            idx = int'((upd_pc / IB) % DEPTH);
            tag = upd_pc / (IB * DEPTH);
            if (m_btb.exists(idx) && m_btb[idx].tag == tag) begin
                if (upd_taken) begin
                    m_btb[idx].ctr    = (m_btb[idx].ctr == 3) ? 3 : m_btb[idx].ctr + 1;
                    m_btb[idx].target = upd_target;
                end else begin
                    m_btb[idx].ctr = (m_btb[idx].ctr == 0) ? 0 : m_btb[idx].ctr - 1;
                end
            end else if (upd_taken) begin
                m_btb[idx] = '{tag: tag, target: upd_target, ctr: 2};
            end
        end
        exp_q.push_back(m_pc);
    endtask

    task automatic check_state(input string tag);
        bit            pt;
        logic [AW-1:0] ptg;
        check({tag, "_pc"}, 64'(pc_o), 64'(exp_q.pop_front()));
        check({tag, "_pc_valid"}, 64'(pc_valid_o), 64'(m_valid));
        check({tag, "_epoch"}, 64'(epoch_o), 64'(m_epoch));
        model_lookup(m_pc, pt, ptg);
        check({tag, "_pred_taken"}, 64'(pred_taken_o), 64'(pt));
        if (pt) check({tag, "_pred_target"}, 64'(pred_target_o), 64'(ptg));
    endtask

    // ---------------- driver ----------------
    task automatic set_idle();
        stall      = 1'b0;
        rdr_valid  = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
    endtask

    // One clock: model consumes the current inputs, DUT takes the edge, both compared #1 later.
    task automatic cycle(input string tag);
        if (!rst) model_step();
        else exp_q.push_back(m_pc);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic set_rdr(input int k, input logic [AW-1:0] tgt);
        rdr_valid[k]            = 1'b1;
        rdr_target[k*AW +: AW]  = tgt;
    endtask

    task automatic btb_train(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic taken);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = taken;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        rdr_target = '0;
        rst        = 1'b1;
        model_reset();

        // T1: reset and sequential fetch
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(m_pc);
        check_state("t1_in_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.push_back(m_pc);
        check_state("t1_released");
        check("t1_valid_low", 64'(pc_valid_o), 64'd0);
        cycle("t1_c1");
        check("t1_pc4", 64'(pc_o), 64'h4);
        cycle("t1_c2");
        cycle("t1_c3");
        check("t1_pcC", 64'(pc_o), 64'hC);
        check("t1_epoch0", 64'(epoch_o), 64'd0);

        // T2: priority and alignment
        set_rdr(1, 32'h200);
        set_rdr(0, 32'h100);
        cycle("t2_both");
        check("t2_pc200", 64'(pc_o), 64'h200);
        check("t2_epoch1", 64'(epoch_o), 64'd1);
        rdr_valid = '0;
        set_rdr(0, 32'h202);
        cycle("t2_align");
        check("t2_aligned", 64'(pc_o), 64'h200);
        set_idle();

        // T3: redirects captured while stalled, newest wins
        stall = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            rdr_valid = '0;
            if (c == 1) set_rdr(0, 32'h40);
            if (c == 3) set_rdr(1, 32'h80);
            cycle("t3_stall");
            check("t3_hold", 64'(pc_o), 64'h200);
        end
        set_idle();
        cycle("t3_release");
        check("t3_pc80", 64'(pc_o), 64'h80);
        cycle("t3_next");
        check("t3_pc84", 64'(pc_o), 64'h84);
        check("t3_epoch", 64'(epoch_o), 64'd4);

        // T4: BTB training and un-training
        stall = 1'b1;
        btb_train(32'h10, 32'h300, 1'b1);
        cycle("t4_train1");
        cycle("t4_train2");
        set_idle();
        set_rdr(0, 32'h0);
        cycle("t4_to0");
        rdr_valid = '0;
        repeat (4) cycle("t4_seq");
        check("t4_at10", 64'(pc_o), 64'h10);
        check("t4_pred", 64'(pred_taken_o), 64'd1);
        check("t4_pred_tgt", 64'(pred_target_o), 64'h300);
        cycle("t4_follow");
        check("t4_pc300", 64'(pc_o), 64'h300);
        stall = 1'b1;
        btb_train(32'h10, 32'h300, 1'b0);
        cycle("t4_nt1");
        cycle("t4_nt2");
        set_idle();
        set_rdr(0, 32'h10);
        cycle("t4_back10");
        check("t4_pred_off", 64'(pred_taken_o), 64'd0);

        // T5: redirect beats a taken prediction
        set_idle();
        stall = 1'b1;
        btb_train(32'h10, 32'h300, 1'b1);
        cycle("t5_train1");
        cycle("t5_train2");
        check("t5_pred_on", 64'(pred_taken_o), 64'd1);
        set_idle();
        set_rdr(0, 32'h500);
        cycle("t5_redirect");
        check("t5_pc500", 64'(pc_o), 64'h500);
        set_idle();

        // T6: async reset mid-stall with a pending redirect; no BTB update under reset
        stall = 1'b1;
        set_rdr(1, 32'h80);
        cycle("t6_pend");
        rdr_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(m_pc);
        check_state("t6_async");
        check("t6_pc_rv", 64'(pc_o), 64'h0);
        btb_train(32'h10, 32'h700, 1'b1);
        cycle("t6_rst_upd1");
        cycle("t6_rst_upd2");
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        cycle("t6_after");
        check("t6_no_pend", 64'(pc_o), 64'h4);
        set_rdr(0, 32'h10);
        cycle("t6_to10");
        check("t6_btb_empty", 64'(pred_taken_o), 64'd0);
        set_idle();

        // T7: sequential wrap at the top of the address space
        set_rdr(0, 32'hFFFF_FFFC);
        cycle("t7_top");
        set_idle();
        cycle("t7_wrap");
        check("t7_pc0", 64'(pc_o), 64'h0);

        // Randomized traffic over a small address window so the BTB aliases and retrains.
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NR; k++) begin
                rdr_valid[k]           = ($urandom_range(0, 5) == 0);
                rdr_target[k*AW +: AW] = 32'($urandom_range(0, 'h3FF));
            end
            upd_valid  = ($urandom_range(0, 1) == 1);
            upd_pc     = 32'($urandom_range(0, 63) * IB);
            upd_target = 32'($urandom_range(0, 255) * IB);
            upd_taken  = ($urandom_range(0, 2) != 0);
            cycle("rnd");
        end
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
